// File: rtl/reg_access_initiator.sv
// reg_access_initiator: issues register reads/writes as byte packets and
// matches read responses, with a response timeout.
package uart_pkg;
   typedef struct packed {
      logic [7:0] Source;
      logic [7:0] Destination;
      logic [7:0] Length;
      logic       SoP;
      logic       EoP;
      logic [7:0] Data;
      logic       Valid;
   } UART_PACKET;
endpackage

module reg_access_initiator
   import uart_pkg::*;
#(
   parameter logic [7:0] LOCAL_ID       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic        ipClk,
   input  logic        ipReset,
   input  logic        ipCmdValid,
   output logic        opCmdReady,
   input  logic        ipCmdWrite,
   input  logic [7:0]  ipCmdAddress,
   input  logic [31:0] ipCmdWrData,
   output UART_PACKET  opTxStream,
   input  logic        ipTxReady,
   input  UART_PACKET  ipRxStream,
   output logic        opRspValid,
   output logic [31:0] opRspRdData,
   output logic        opRspTimeout
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] TX_ADDR  = 3'd1;
   localparam logic [2:0] TX_PAY   = 3'd2;
   localparam logic [2:0] WAIT_RSP = 3'd3;
   localparam logic [2:0] RX_PAY   = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   logic [2:0]    state;
   logic          run;
   logic          wr;
   logic [7:0]    addr;
   logic [31:0]   wdata;
   logic [1:0]    cnt;
   logic          discard;
   logic [31:0]   rx_data;
   logic [TW-1:0] timer;
   logic          tx_fire;
   logic          rx_byte;
   logic          match;
   logic          timer_hit;
   logic          unused;

   assign tx_fire    = opTxStream.Valid && ipTxReady;
   assign rx_byte    = ipRxStream.Valid;
   assign match      = ipRxStream.SoP && ipRxStream.Destination == LOCAL_ID && ipRxStream.Data == addr;
   assign timer_hit  = timer == TW'(TIMEOUT_CYCLES - 1);
   assign opCmdReady = run && state == IDLE;
   assign opRspValid = state == DONE;
   assign unused     = ^{ipRxStream.Source, ipRxStream.Length};

   // Tx fields are derived from latched command state, so they stay stable under backpressure.
   always_comb begin
      opTxStream = '0;
      if (state == TX_ADDR || state == TX_PAY) begin
         opTxStream.Source      = LOCAL_ID;
         opTxStream.Destination = {7'd0, wr};
         opTxStream.Length      = wr ? 8'd5 : 8'd1;
         opTxStream.SoP         = state == TX_ADDR;
         opTxStream.EoP         = state == TX_ADDR ? !wr : cnt == 2'd3;
         opTxStream.Data        = state == TX_ADDR ? addr : wdata[7:0];
         opTxStream.Valid       = 1'b1;
      end
   end

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state        <= IDLE;
         run          <= 1'b0;
         wr           <= 1'b0;
         addr         <= '0;
         wdata        <= '0;
         cnt          <= '0;
         discard      <= 1'b0;
         rx_data      <= '0;
         timer        <= '0;
         opRspRdData  <= '0;
         opRspTimeout <= 1'b0;
      end else begin
         run <= 1'b1;
         case (state)
            IDLE: if (opCmdReady && ipCmdValid) begin
               wr    <= ipCmdWrite;
               addr  <= ipCmdAddress;
               wdata <= ipCmdWrData;
               state <= TX_ADDR;
            end
            TX_ADDR: if (tx_fire) begin
               cnt     <= '0;
               timer   <= '0;
               discard <= 1'b0;
               state   <= wr ? TX_PAY : WAIT_RSP;
            end
            TX_PAY: if (tx_fire) begin
               cnt   <= cnt + 2'd1;
               wdata <= wdata >> 8;
               if (cnt == 2'd3) begin
                  opRspTimeout <= 1'b0;
                  state        <= DONE;
               end
            end
            WAIT_RSP: begin
               timer <= timer + 1'b1;
               if (timer_hit) begin
                  opRspTimeout <= 1'b1;
                  opRspRdData  <= '0;
                  state        <= DONE;
               end else if (rx_byte) begin
                  if (discard)
                     discard <= !ipRxStream.EoP;
                  else if (match) begin
                     cnt   <= '0;
                     state <= RX_PAY;
                  end else if (ipRxStream.SoP)
                     discard <= !ipRxStream.EoP;
               end
            end
            RX_PAY: begin
               timer <= timer + 1'b1;
               // A completing byte takes priority over a coincident timeout.
               if (rx_byte && cnt == 2'd3) begin
                  opRspTimeout <= 1'b0;
                  opRspRdData  <= {ipRxStream.Data, rx_data[31:8]};
                  state        <= DONE;
               end else if (timer_hit) begin
                  opRspTimeout <= 1'b1;
                  opRspRdData  <= '0;
                  state        <= DONE;
               end else if (rx_byte) begin
                  rx_data <= {ipRxStream.Data, rx_data[31:8]};
                  cnt     <= cnt + 2'd1;
                  if (ipRxStream.EoP)
                     state <= WAIT_RSP;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
